// File: rtl/l1_line_fill_if.sv
// rtl/l1_line_fill_if.sv - request, memory return and data-RAM write bundle for the line-fill engine
interface l1_line_fill_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BEATS      = 4
);
  localparam int BW = $clog2(BEATS);
  localparam int LW = ADDR_WIDTH - BW;

  logic                  req_valid;
  logic                  req_ready;
  logic [LW-1:0]         req_line;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [LW-1:0]         mem_req_line;
  logic                  mem_rvalid;
  logic                  mem_rready;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rerr;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  busy;
  logic                  done_valid;
  logic                  done_err;

  // Engine side
  modport slave (
    input  req_valid, req_line, mem_req_ready, mem_rvalid, mem_rdata, mem_rerr,
    output req_ready, mem_req_valid, mem_req_line, mem_rready,
           wen, waddr, wdata, busy, done_valid, done_err
  );

  // Cache / memory side
  modport master (
    output req_valid, req_line, mem_req_ready, mem_rvalid, mem_rdata, mem_rerr,
    input  req_ready, mem_req_valid, mem_req_line, mem_rready,
           wen, waddr, wdata, busy, done_valid, done_err
  );
endinterface

// File: rtl/l1_line_fill.sv
// rtl/l1_line_fill.sv - L1 cache-line refill engine driving the data-RAM write port
module l1_line_fill #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BEATS      = 4
) (
  input logic          clk,
  input logic          rst,
  l1_line_fill_if.slave bus
);
  localparam int BW = $clog2(BEATS);
  localparam int LW = ADDR_WIDTH - BW;

  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

  state_t                state_q, state_d;
  logic [LW-1:0]         line_q, line_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic                  err_q, err_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  // State and write-port registers; reset drops any pending write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      line_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state: latch the line, hand it to memory, write beats in arrival order
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    beat_d  = beat_q;
    err_d   = err_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          line_d  = bus.req_line;
          beat_d  = '0;
          err_d   = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.mem_req_ready) state_d = FILL;
      end
      FILL: begin
        if (bus.mem_rvalid) begin
          // Error beats are still written; the cache invalidates via done_err
          wen_d   = 1'b1;
          waddr_d = {line_q, beat_q};
          wdata_d = bus.mem_rdata;
          err_d   = err_q | bus.mem_rerr;
          beat_d  = beat_q + BW'(1);
          if (beat_q == BW'(BEATS - 1)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs decode from registered state only
  assign bus.req_ready     = (state_q == IDLE);
  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.mem_req_line  = line_q;
  assign bus.mem_rready    = (state_q == FILL);
  assign bus.busy          = (state_q != IDLE);
  assign bus.done_valid    = (state_q == DONE);
  assign bus.done_err      = (state_q == DONE) && err_q;
  assign bus.wen           = wen_q;
  assign bus.waddr         = waddr_q;
  assign bus.wdata         = wdata_q;
endmodule

// File: tb/tb_l1_line_fill.sv
// tb/tb_l1_line_fill.sv - directed self-checking bench for l1_line_fill
module tb_l1_line_fill;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int LW = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l1_line_fill_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(NB)) bus ();

  l1_line_fill #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_alone = 0;
  logic done_err_seen = 1'b0;
  logic [AW-1:0] wr_addr[$];
  logic [DW-1:0] wr_data[$];
  int done_cyc[$];
  int acc_cyc[$];

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // Observe writes, completions and acceptances mid-cycle
  always @(negedge clk) begin
    if (bus.wen) begin
      wr_addr.push_back(bus.waddr);
      wr_data.push_back(bus.wdata);
    end
    if (bus.done_valid) begin
      done_cnt      <= done_cnt + 1;
      done_err_seen <= bus.done_err;
      done_cyc.push_back(cyc);
      if (!bus.wen) done_alone <= done_alone + 1;
    end
    if (bus.req_valid && bus.req_ready) acc_cyc.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_req(input logic [LW-1:0] line);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_line  = line;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: req_ready=%0b required 1", bus.req_ready);
    end
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic drive_beats(input logic [DW-1:0] base, input int n, input int gap, input int err_beat);
    int k;
    for (int i = 0; i < n; i++) begin
      bus.mem_rvalid = 1'b0;
      repeat (gap) tick();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = base + DW'(i);
      bus.mem_rerr   = (i == err_beat);
      k = 0;
      @(negedge clk);
      while (!bus.mem_rready && k < 100) begin
        @(negedge clk);
        k++;
      end
      checks++;
      if (bus.mem_rready !== 1'b1) begin
        errors++;
        $display("FAIL beat_timeout: mem_rready=%0b required 1", bus.mem_rready);
      end
      tick();
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_rerr   = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_timeout: req_ready=%0b required 1", bus.req_ready);
    end
    tick();
  endtask

  task automatic test_reset();
    logic [6:0] flags;
    repeat (2) @(negedge clk);
    flags = {bus.req_ready, bus.mem_req_valid, bus.mem_rready, bus.wen, bus.busy, bus.done_valid, bus.done_err};
    checks++;
    if (flags !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 1000000", flags);
    end
    checks++;
    if (bus.waddr !== 16'h0 || bus.wdata !== 32'h0 || bus.mem_req_line !== 14'h0) begin
      errors++;
      $display("FAIL reset_data: waddr=%h wdata=%h line=%h required 0", bus.waddr, bus.wdata, bus.mem_req_line);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int b, d, lat, busy_n;
    b = wr_addr.size();
    d = done_cnt;
    bus.mem_req_ready = 1'b1;
    accept_req(14'h0012);
    lat = 0;
    busy_n = 0;
    fork
      drive_beats(32'hA0, 4, 0, -1);
      begin
        do begin
          @(negedge clk);
          lat++;
          if (bus.busy) busy_n++;
        end while (!bus.req_ready && lat < 50);
      end
    join
    tick();
    checks++;
    if (lat !== 7) begin
      errors++;
      $display("FAIL basic_latency: req_ready after %0d cycles required 7", lat);
    end
    checks++;
    if (busy_n !== 6) begin
      errors++;
      $display("FAIL basic_busy: busy for %0d cycles required 6", busy_n);
    end
    checks++;
    if (wr_addr.size() - b !== 4) begin
      errors++;
      $display("FAIL basic_count: %0d writes required 4", wr_addr.size() - b);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_addr[b+i] !== 16'h0048 + AW'(i) || wr_data[b+i] !== 32'hA0 + DW'(i)) begin
          errors++;
          $display("FAIL basic_write%0d: addr=%h data=%h required %h %h", i, wr_addr[b+i], wr_data[b+i],
                   16'h0048 + AW'(i), 32'hA0 + DW'(i));
        end
      end
    end
    checks++;
    if (done_cnt - d !== 1 || done_err_seen !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: pulses=%0d err=%0b required 1 0", done_cnt - d, done_err_seen);
    end
  endtask

  task automatic test_backpressure();
    int b;
    b = wr_addr.size();
    bus.mem_req_ready = 1'b0;
    accept_req(14'h0012);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_req_line !== 14'h0012 || bus.mem_rready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%0b line=%h rready=%0b required 1 0012 0", i,
                 bus.mem_req_valid, bus.mem_req_line, bus.mem_rready);
      end
    end
    bus.mem_req_ready = 1'b1;
    drive_beats(32'hB0, 4, 0, -1);
    wait_idle();
    checks++;
    if (wr_addr.size() - b !== 4 || wr_addr[b] !== 16'h0048 || wr_data[b+3] !== 32'hB3) begin
      errors++;
      $display("FAIL bp_writes: n=%0d first=%h last_data=%h required 4 0048 b3", wr_addr.size() - b,
               wr_addr[b], wr_data[b+3]);
    end
  endtask

  task automatic test_gap_err();
    int b, d;
    b = wr_addr.size();
    d = done_cnt;
    accept_req(14'h0020);
    drive_beats(32'hC0, 4, 2, 2);
    wait_idle();
    checks++;
    if (wr_addr.size() - b !== 4) begin
      errors++;
      $display("FAIL gap_count: %0d writes required 4", wr_addr.size() - b);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_addr[b+i] !== 16'h0080 + AW'(i) || wr_data[b+i] !== 32'hC0 + DW'(i)) begin
          errors++;
          $display("FAIL gap_write%0d: addr=%h data=%h required %h %h", i, wr_addr[b+i], wr_data[b+i],
                   16'h0080 + AW'(i), 32'hC0 + DW'(i));
        end
      end
    end
    checks++;
    if (done_cnt - d !== 1 || done_err_seen !== 1'b1) begin
      errors++;
      $display("FAIL gap_done_err: pulses=%0d err=%0b required 1 1", done_cnt - d, done_err_seen);
    end
  endtask

  task automatic test_spurious();
    int b;
    b = wr_addr.size();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_rready !== 1'b0 || bus.wen !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
        errors++;
        $display("FAIL spur_idle%0d: rready=%0b wen=%0b busy=%0b req_ready=%0b required 0 0 0 1", i,
                 bus.mem_rready, bus.wen, bus.busy, bus.req_ready);
      end
    end
    tick();
    bus.mem_req_ready = 1'b0;
    accept_req(14'h0030);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_rready !== 1'b0 || bus.wen !== 1'b0 || bus.mem_req_valid !== 1'b1) begin
        errors++;
        $display("FAIL spur_req%0d: rready=%0b wen=%0b mem_req_valid=%0b required 0 0 1", i,
                 bus.mem_rready, bus.wen, bus.mem_req_valid);
      end
    end
    bus.mem_rvalid    = 1'b0;
    bus.mem_req_ready = 1'b1;
    drive_beats(32'hD0, 4, 0, -1);
    wait_idle();
    checks++;
    if (wr_addr.size() - b !== 4 || wr_addr[b] !== 16'h00C0 || wr_data[b] !== 32'hD0) begin
      errors++;
      $display("FAIL spur_first: n=%0d addr=%h data=%h required 4 00c0 d0", wr_addr.size() - b,
               wr_addr[b], wr_data[b]);
    end
  endtask

  task automatic test_reset_mid();
    int b, d;
    logic [6:0] flags;
    b = wr_addr.size();
    d = done_cnt;
    accept_req(14'h0005);
    drive_beats(32'hE0, 2, 0, -1);
    #1;
    rst = 1'b1;
    #1;
    flags = {bus.req_ready, bus.mem_req_valid, bus.mem_rready, bus.wen, bus.busy, bus.done_valid, bus.done_err};
    checks++;
    if (flags !== 7'b1000000 || bus.waddr !== 16'h0 || bus.wdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_async: flags=%b waddr=%h wdata=%h required 1000000 0 0", flags, bus.waddr, bus.wdata);
    end
    repeat (2) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (done_cnt - d !== 0 || wr_addr.size() - b !== 1) begin
      errors++;
      $display("FAIL rst_abort: pulses=%0d writes=%0d required 0 1", done_cnt - d, wr_addr.size() - b);
    end
    b = wr_addr.size();
    accept_req(14'h3FFF);
    drive_beats(32'hF0, 4, 0, -1);
    wait_idle();
    checks++;
    if (wr_addr.size() - b !== 4) begin
      errors++;
      $display("FAIL rst_refill_count: %0d writes required 4", wr_addr.size() - b);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_addr[b+i] !== 16'hFFFC + AW'(i) || wr_data[b+i] !== 32'hF0 + DW'(i)) begin
          errors++;
          $display("FAIL rst_refill%0d: addr=%h data=%h required %h %h", i, wr_addr[b+i], wr_data[b+i],
                   16'hFFFC + AW'(i), 32'hF0 + DW'(i));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int b, dcs, acs, n;
    b = wr_addr.size();
    dcs = done_cyc.size();
    acs = acc_cyc.size();
    fork
      begin
        bus.req_valid = 1'b1;
        bus.req_line  = 14'h0001;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
        tick();
        bus.req_line = 14'h0002;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
        tick();
        bus.req_valid = 1'b0;
      end
      drive_beats(32'h100, 8, 0, -1);
    join
    wait_idle();
    checks++;
    if (acc_cyc.size() - acs !== 2 || done_cyc.size() - dcs !== 2) begin
      errors++;
      $display("FAIL b2b_counts: accepts=%0d dones=%0d required 2 2", acc_cyc.size() - acs, done_cyc.size() - dcs);
    end else begin
      checks++;
      if (acc_cyc[acs+1] !== done_cyc[dcs] + 1) begin
        errors++;
        $display("FAIL b2b_spacing: second accept cycle %0d required %0d", acc_cyc[acs+1], done_cyc[dcs] + 1);
      end
    end
    checks++;
    if (wr_addr.size() - b !== 8) begin
      errors++;
      $display("FAIL b2b_count: %0d writes required 8", wr_addr.size() - b);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (wr_addr[b+i] !== 16'h0004 + AW'(i) || wr_data[b+i] !== 32'h100 + DW'(i)) begin
          errors++;
          $display("FAIL b2b_write%0d: addr=%h data=%h required %h %h", i, wr_addr[b+i], wr_data[b+i],
                   16'h0004 + AW'(i), 32'h100 + DW'(i));
        end
      end
    end
    checks++;
    if (done_alone !== 0) begin
      errors++;
      $display("FAIL done_with_wen: %0d done pulses without wen required 0", done_alone);
    end
  endtask

  initial begin
    bus.req_valid     = 1'b0;
    bus.req_line      = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rvalid    = 1'b0;
    bus.mem_rdata     = '0;
    bus.mem_rerr      = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_gap_err();
    test_spurious();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/l1_line_fill.md
# l1_line_fill

Cache-line refill engine for the L1 cache. On a miss it accepts a line index, issues one line request to the next memory level, collects `BEATS` data beats over a valid/ready return channel, and drives the write port of the L1 data RAM (`wen`/`waddr`/`wdata`) one word per beat. It completes with a one-cycle done pulse carrying an error flag. It is the writer side of the cache data RAM; the lookup path remains the reader.

## Interface

- `ADDR_WIDTH`, 16, data-RAM word address width.
- `DATA_WIDTH`, 32, data-RAM word width and memory beat width.
- `BEATS`, 4, words per line; power of two, ≥2. `BW = $clog2(BEATS)`. Line index width `LW = ADDR_WIDTH-BW`.

Ports (clock and reset first):

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: fill request.
- `req_ready` out 1: engine idle, request accepted when `req_valid & req_ready`.
- `req_line` in LW: line index to fill.
- `mem_req_valid` out 1: line request to memory.
- `mem_req_ready` in 1: memory accepts line request.
- `mem_req_line` out LW: requested line index.
- `mem_rvalid` in 1: return beat valid.
- `mem_rready` out 1: engine accepts return beat.
- `mem_rdata` in DATA_WIDTH: return beat data.
- `mem_rerr` in 1: return beat error.
- `wen` out 1: data-RAM write enable.
- `waddr` out ADDR_WIDTH: data-RAM write address.
- `wdata` out DATA_WIDTH: data-RAM write data.
- `busy` out 1: state ≠ IDLE.
- `done_valid` out 1: one-cycle completion pulse.
- `done_err` out 1: any beat of the fill had `mem_rerr`; valid only with `done_valid`.

## Operation

- FSM states: IDLE, REQ, FILL, DONE. Reset state is IDLE.
- **IDLE**
  - `req_ready=1`.
  - On handshake: latch `req_line` into `line_q`, clear `beat_q` and `err_q`, go to REQ.
- **REQ**
  - `mem_req_valid=1`, `mem_req_line=line_q`. Both are held stable until `mem_req_ready`.
  - On `mem_req_ready`: go to FILL.
- **FILL**
  - `mem_rready=1`.
  - Each beat (`mem_rvalid & mem_rready`):
    - register `wen=1`, `waddr={line_q, beat_q}`, `wdata=mem_rdata` for exactly the next cycle;
    - `err_q |= mem_rerr`;
    - `beat_q += 1` (BW bits, wraps to 0 after the last beat).
  - When the beat with `beat_q==BEATS-1` is accepted: go to DONE.
- **DONE**
  - `done_valid=1` and `done_err=err_q` for one cycle. This cycle coincides with the final `wen` cycle.
  - Next cycle: go to IDLE.
- Beats are written in arrival order to consecutive addresses, with no critical-word reordering.
- Error beats are still written. The cache uses `done_err` to keep the line invalid.
- Outside FILL:
  - `mem_rready=0`;
  - `mem_rvalid` is ignored and causes no write and no state change.
- `mem_req_valid=1` only in REQ. `req_ready=1` only in IDLE. New requests are never queued.

## Timing

- Reset values:
  - `req_ready=1` (IDLE);
  - `mem_req_valid=0`, `mem_rready=0`, `wen=0`, `busy=0`, `done_valid=0`, `done_err=0`;
  - `waddr=0`, `wdata=0`, and `line_q`, `beat_q`, `err_q` = 0.
- `req_ready`, `mem_req_valid`, `mem_rready`, `busy` and `done_valid` decode directly from registered state, with no combinational path from inputs.
- `wen`, `waddr` and `wdata` are flops. Write latency is 1 cycle from beat acceptance; the RAM commits at the following edge.
- Request accepted at edge T:
  - `mem_req_valid` is high from T+1.
  - With `mem_req_ready` tied high and beats back-to-back, the first beat is accepted at T+2 and the last at T+1+BEATS.
  - `done_valid` is high in the cycle after the last beat.
  - `req_ready` returns one cycle later.
- Minimum fill-to-fill spacing is BEATS+3 cycles.
- Gaps in `mem_rvalid` stall the engine. `wen` is low during gaps.
- Reset asserted mid-operation:
  - immediate return to IDLE with all outputs at their reset values;
  - any registered pending write is dropped;
  - no `done_valid` for the aborted fill.
- `busy` is high from the cycle after request acceptance through the DONE cycle inclusive.

## Test plan

1. **Basic fill.** `BEATS=4`, `req_line=0x0012`, `mem_req_ready=1`, beats `0xA0..0xA3` back-to-back, no error.
   - Writes go to `0x0048..0x004B` with data `0xA0..0xA3`.
   - `done_valid` pulses once with `done_err=0`.
   - `req_ready` returns exactly 7 cycles after acceptance.
2. **Backpressure.** `mem_req_ready` is held low for 5 cycles.
   - `mem_req_valid` and `mem_req_line=0x0012` stay stable for all 5 cycles.
   - No `mem_rready` until the handshake.
3. **Gapped beats with error.** Beats arrive with 2-cycle gaps; beat 2 has `mem_rerr=1`.
   - All 4 words are written, one `wen` per beat, `wen` low during gaps.
   - `done_err=1`.
4. **Spurious beats.** `mem_rvalid=1` is driven while in IDLE and REQ.
   - `mem_rready=0`, no `wen`, no state change.
   - The subsequent fill's first write goes to beat 0.
5. **Reset mid-fill.** `rst` is asserted after 2 of 4 beats.
   - All outputs go to reset values asynchronously; no `done_valid`.
   - A new fill of `req_line=0x3FFF` writes `0xFFFC..0xFFFF`, covering max index and beat wrap.
6. **Back-to-back requests.** `req_valid` is held high with lines 0x0001 and then 0x0002.
   - The second request is accepted only in the IDLE cycle after DONE.
   - Both lines are written correctly with no overlap.
